// File: rtl/sw_operand_sequencer.sv
// Switch-driven operand entry for picoMIPS: debounces the handshake switch, captures X/Y,
// hands them to the core over valid/ready and shows the returned result on the LEDs.
module sw_operand_sequencer #(
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              sw_strobe,
  output logic [DATA_W-1:0] op_data,
  output logic              op_valid,
  input  logic              op_ready,
  output logic              op_sel,
  input  logic [DATA_W-1:0] res_data,
  input  logic              res_we,
  output logic [DATA_W-1:0] led,
  output logic              busy
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [2:0] {
    WAIT_X, REL_X, WAIT_Y, REL_Y, DELIVER_X, DELIVER_Y, WAIT_RES, SHOW
  } state_e;

  state_e            state_q, state_d;
  logic              sync1_q, sync1_d, sync2_q, sync2_d;
  logic              db_q, db_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] x_q, x_d, y_q, y_d, res_q, res_d;
  logic [DATA_W-1:0] op_data_q, op_data_d, led_q, led_d;
  logic              op_valid_q, op_valid_d, op_sel_q, op_sel_d, busy_q, busy_d;
  logic              db_rise_c, db_fall_c, handshake_c;

  // Two-flop synchroniser followed by a stability counter.
  always_comb begin
    sync1_d   = sw_strobe;
    sync2_d   = sync1_q;
    db_d      = db_q;
    cnt_d     = '0;
    db_rise_c = 1'b0;
    db_fall_c = 1'b0;
    if (sync2_q != db_q) begin
      if (cnt_q + CNT_W'(1) == CNT_LIMIT) begin
        db_d      = sync2_q;
        db_rise_c = sync2_q;
        db_fall_c = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign handshake_c = op_valid_q & op_ready;

  // Entry / delivery sequencing; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    led_d   = led_q;
    unique case (state_q)
      WAIT_X: begin
        led_d = sw_data;
        if (db_rise_c) begin x_d = sw_data; state_d = REL_X; end
      end
      REL_X: begin
        led_d = x_q;
        if (db_fall_c) state_d = WAIT_Y;
      end
      WAIT_Y: begin
        led_d = sw_data;
        if (db_rise_c) begin y_d = sw_data; state_d = REL_Y; end
      end
      REL_Y: begin
        led_d = y_q;
        if (db_fall_c) state_d = DELIVER_X;
      end
      DELIVER_X: if (handshake_c) state_d = DELIVER_Y;
      DELIVER_Y: if (handshake_c) state_d = WAIT_RES;
      WAIT_RES: if (res_we) begin res_d = res_data; state_d = SHOW; end
      SHOW: begin
        led_d = res_q;
        if (db_rise_c) begin x_d = sw_data; state_d = REL_X; end
      end
      default: state_d = WAIT_X;
    endcase

    op_valid_d = (state_d == DELIVER_X) || (state_d == DELIVER_Y);
    op_sel_d   = (state_d == DELIVER_Y);
    busy_d     = op_valid_d || (state_d == WAIT_RES);
    op_data_d  = (state_d == DELIVER_X) ? x_q :
                 (state_d == DELIVER_Y) ? y_q : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= WAIT_X;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_q       <= 1'b0;
      cnt_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      res_q      <= '0;
      led_q      <= '0;
      op_data_q  <= '0;
      op_valid_q <= 1'b0;
      op_sel_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_q       <= db_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      res_q      <= res_d;
      led_q      <= led_d;
      op_data_q  <= op_data_d;
      op_valid_q <= op_valid_d;
      op_sel_q   <= op_sel_d;
      busy_q     <= busy_d;
    end
  end

  assign op_data  = op_data_q;
  assign op_valid = op_valid_q;
  assign op_sel   = op_sel_q;
  assign led      = led_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_sw_operand_sequencer.sv
// Directed bench for sw_operand_sequencer: debounce timing, capture, delivery and boundary cases.
module tb_sw_operand_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sw_data;
  logic       sw_strobe;
  logic [7:0] op_data;
  logic       op_valid;
  logic       op_ready;
  logic       op_sel;
  logic [7:0] res_data;
  logic       res_we;
  logic [7:0] led;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;

  sw_operand_sequencer #(.DATA_W(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .sw_data(sw_data), .sw_strobe(sw_strobe),
    .op_data(op_data), .op_valid(op_valid), .op_ready(op_ready), .op_sel(op_sel),
    .res_data(res_data), .res_we(res_we), .led(led), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Raise the strobe cleanly: db rises on the 6th edge, led shows X/Y on the 7th.
  task automatic press(input logic [7:0] d);
    sw_data   = d;
    sw_strobe = 1'b1;
    repeat (7) tick();
  endtask

  // Drop the strobe cleanly and stop on the edge where db falls.
  task automatic release_sw();
    sw_strobe = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; sw_data = 8'hC3; sw_strobe = 1'b0;
    op_ready = 1'b0; res_data = 8'h00; res_we = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    n_cmp++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL reset_op_valid got %0b want 0", op_valid); end
    n_cmp++; if (op_data !== 8'h00) begin n_fail++; $display("FAIL reset_op_data got %h want 00", op_data); end
    n_cmp++; if (op_sel !== 1'b0) begin n_fail++; $display("FAIL reset_op_sel got %0b want 0", op_sel); end
    n_cmp++; if (led !== 8'h00) begin n_fail++; $display("FAIL reset_led got %h want 00", led); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
  endtask

  task automatic test_debounce_capture();
    do_reset();
    sw_data = 8'h2A; sw_strobe = 1'b1;
    repeat (5) tick();
    n_cmp++; if (dut.db_q !== 1'b0) begin n_fail++; $display("FAIL db_early got %0b want 0", dut.db_q); end
    tick();
    n_cmp++; if (dut.db_q !== 1'b1) begin n_fail++; $display("FAIL db_rise_edge6 got %0b want 1", dut.db_q); end
    sw_data = 8'h33;
    tick();
    n_cmp++; if (led !== 8'h2A) begin n_fail++; $display("FAIL capture_x_led got %h want 2a", led); end
    sw_strobe = 1'b0;
    repeat (5) tick();
    n_cmp++; if (dut.db_q !== 1'b1) begin n_fail++; $display("FAIL db_fall_early got %0b want 1", dut.db_q); end
    tick();
    n_cmp++; if (dut.db_q !== 1'b0) begin n_fail++; $display("FAIL db_fall_edge6 got %0b want 0", dut.db_q); end
    n_cmp++; if (led !== 8'h2A) begin n_fail++; $display("FAIL rel_x_led got %h want 2a", led); end
    tick();
    n_cmp++; if (led !== 8'h33) begin n_fail++; $display("FAIL wait_y_echo got %h want 33", led); end
  endtask

  task automatic test_bounce();
    logic seen_rise;
    do_reset();
    sw_data = 8'h5C;
    seen_rise = 1'b0;
    sw_strobe = 1'b1; repeat (3) begin tick(); seen_rise |= dut.db_q; end
    sw_strobe = 1'b0; repeat (2) begin tick(); seen_rise |= dut.db_q; end
    sw_strobe = 1'b1; tick(); seen_rise |= dut.db_q;
    sw_strobe = 1'b0; repeat (10) begin tick(); seen_rise |= dut.db_q; end
    n_cmp++; if (seen_rise !== 1'b0) begin n_fail++; $display("FAIL bounce_db got %0b want 0", seen_rise); end
    n_cmp++; if (led !== 8'h5C) begin n_fail++; $display("FAIL bounce_led got %h want 5c", led); end
    sw_data = 8'h99; tick(); tick();
    n_cmp++; if (led !== 8'h99) begin n_fail++; $display("FAIL bounce_echo got %h want 99", led); end
    n_cmp++; if (dut.x_q !== 8'h00) begin n_fail++; $display("FAIL bounce_x got %h want 00", dut.x_q); end
  endtask

  task automatic test_full_transaction();
    do_reset();
    press(8'h05); release_sw();
    press(8'hF0); release_sw();
    n_cmp++; if (op_valid !== 1'b1) begin n_fail++; $display("FAIL dx_valid got %0b want 1", op_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL dx_busy got %0b want 1", busy); end
    op_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (op_data !== 8'h05 || op_sel !== 1'b0 || op_valid !== 1'b1) begin
        n_fail++; $display("FAIL dx_hold%0d got data=%h sel=%0b valid=%0b want 05/0/1", i, op_data, op_sel, op_valid);
      end
      tick();
    end
    n_cmp++;
    if (op_data !== 8'h05 || op_sel !== 1'b0) begin
      n_fail++; $display("FAIL dx_hold3 got data=%h sel=%0b want 05/0", op_data, op_sel);
    end
    op_ready = 1'b1;
    tick();
    n_cmp++;
    if (op_data !== 8'hF0 || op_sel !== 1'b1 || op_valid !== 1'b1) begin
      n_fail++; $display("FAIL dy got data=%h sel=%0b valid=%0b want f0/1/1", op_data, op_sel, op_valid);
    end
    res_we = 1'b1; res_data = 8'hEE;
    tick();
    op_ready = 1'b0; res_we = 1'b0;
    n_cmp++;
    if (op_valid !== 1'b0 || op_data !== 8'h00 || busy !== 1'b1) begin
      n_fail++; $display("FAIL wait_res got valid=%0b data=%h busy=%0b want 0/00/1", op_valid, op_data, busy);
    end
    repeat (2) tick();
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL early_res_we got busy=%0b want 1", busy); end
    res_we = 1'b1; res_data = 8'h77;
    tick();
    res_we = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL show_busy got %0b want 0", busy); end
    tick();
    n_cmp++; if (led !== 8'h77) begin n_fail++; $display("FAIL show_led got %h want 77", led); end
  endtask

  task automatic test_reentry();
    press(8'h11);
    n_cmp++; if (led !== 8'h11) begin n_fail++; $display("FAIL reentry_led got %h want 11", led); end
    n_cmp++; if (dut.x_q !== 8'h11) begin n_fail++; $display("FAIL reentry_x got %h want 11", dut.x_q); end
    release_sw();
    press(8'h22); release_sw();
    n_cmp++;
    if (op_valid !== 1'b1 || op_data !== 8'h11) begin
      n_fail++; $display("FAIL reentry_dx got valid=%0b data=%h want 1/11", op_valid, op_data);
    end
    op_ready = 1'b1;
    tick();
    n_cmp++;
    if (op_data !== 8'h22 || op_sel !== 1'b1) begin
      n_fail++; $display("FAIL reentry_dy got data=%h sel=%0b want 22/1", op_data, op_sel);
    end
    tick();
    op_ready = 1'b0;
    res_we = 1'b1; res_data = 8'h33;
    tick();
    res_we = 1'b0;
    tick();
    n_cmp++; if (led !== 8'h33) begin n_fail++; $display("FAIL reentry_result got %h want 33", led); end
  endtask

  task automatic test_stray_events();
    do_reset();
    res_we = 1'b1; res_data = 8'hAB; op_ready = 1'b1;
    tick();
    res_we = 1'b0; op_ready = 1'b0;
    n_cmp++;
    if (op_valid !== 1'b0 || busy !== 1'b0 || dut.res_q !== 8'h00) begin
      n_fail++; $display("FAIL stray_wait_x got valid=%0b busy=%0b res=%h want 0/0/00", op_valid, busy, dut.res_q);
    end
    press(8'h12); release_sw();
    res_we = 1'b1; res_data = 8'hCD;
    tick();
    res_we = 1'b0;
    press(8'h34);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    n_cmp++;
    if (op_valid !== 1'b0 || busy !== 1'b0 || led !== 8'h34 || dut.res_q !== 8'h00) begin
      n_fail++; $display("FAIL stray_rel_y got valid=%0b busy=%0b led=%h res=%h want 0/0/34/00", op_valid, busy, led, dut.res_q);
    end
    release_sw();
    n_cmp++;
    if (op_valid !== 1'b1 || op_data !== 8'h12) begin
      n_fail++; $display("FAIL stray_then_dx got valid=%0b data=%h want 1/12", op_valid, op_data);
    end
  endtask

  task automatic test_reset_mid();
    op_ready = 1'b1;
    tick();
    n_cmp++;
    if (op_valid !== 1'b1 || op_sel !== 1'b1 || op_data !== 8'h34) begin
      n_fail++; $display("FAIL mid_dy got valid=%0b sel=%0b data=%h want 1/1/34", op_valid, op_sel, op_data);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; op_ready = 1'b0;
    n_cmp++;
    if (op_valid !== 1'b0 || led !== 8'h00 || busy !== 1'b0 || op_data !== 8'h00 || op_sel !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset got valid=%0b led=%h busy=%0b data=%h sel=%0b want 0/00/0/00/0", op_valid, led, busy, op_data, op_sel);
    end
    res_we = 1'b1; res_data = 8'h66;
    tick();
    res_we = 1'b0;
    tick();
    n_cmp++;
    if (led !== 8'h34 || dut.res_q !== 8'h00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_after got led=%h res=%h busy=%0b want 34/00/0", led, dut.res_q, busy);
    end
  endtask

  initial begin
    test_reset();
    test_debounce_capture();
    test_bounce();
    test_full_transaction();
    test_reentry();
    test_stray_events();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
